quad_encoder_gen: RTL and testbench
===================================

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

Interface
REQ-001 SHALL have parameter STEP_PERIOD, default 98304, meaning clocks between successive quadrature transitions (min 4).
REQ-002 SHALL have parameter BOUNCE_COUNT, default 3, meaning bounce pulses injected per edge (used only under REQ-031).
REQ-003 SHALL have parameter BOUNCE_CYCLES, default 64, meaning clocks per bounce level (used only under REQ-031).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  rotation command request.
REQ-007 SHALL have port cmd_ready  output  1  generator idle, command accepted when cmd_valid & cmd_ready.
REQ-008 SHALL have port cmd_clockwise  input  1  1 = clockwise, 0 = counter-clockwise.
REQ-009 SHALL have port cmd_steps  input  8  number of quadrature transitions to emit.
REQ-010 SHALL have port sw_valid  input  1  switch-press request.
REQ-011 SHALL have port sw_ready  output  1  switch generator idle.
REQ-012 SHALL have port sw_hold  input  16  press duration in clocks.
REQ-013 SHALL have port encoder_A  output  1  quadrature phase A.
REQ-014 SHALL have port encoder_B  output  1  quadrature phase B.
REQ-015 SHALL have port encoder_sw  output  1  switch line, idle 1, pressed 0.
REQ-016 SHALL have port busy  output  1  rotation in progress (= ~cmd_ready).
REQ-017 SHALL have port done_stb  output  1  one-cycle pulse at rotation-command completion.

Function
REQ-018 SHALL hold a 2-bit phase index q mapped to {B,A}: 0=00, 1=01, 2=11, 3=10.
REQ-019 SHALL, per clockwise transition, set q <= q+1 mod 4 (BA 00->01->11->10->00); per counter-clockwise, q <= q-1 mod 4.
REQ-020 SHALL change exactly one of encoder_A/encoder_B per transition; q wraps without glitch.
REQ-021 SHALL latch cmd_clockwise and cmd_steps on acceptance; later input changes SHALL be ignored until completion.
REQ-022 SHALL use states IDLE, WAIT, STEP, DONE: IDLE->WAIT on accept with nonzero steps; WAIT counts STEP_PERIOD clocks then ->STEP; STEP applies one transition, decrements remaining, ->WAIT if remaining>0 else ->DONE; DONE pulses done_stb one cycle ->IDLE.
REQ-023 SHALL emit the first transition STEP_PERIOD clocks after the acceptance edge and subsequent transitions every STEP_PERIOD clocks.
REQ-024 SHALL deassert cmd_ready from the cycle after acceptance until the cycle after done_stb.
REQ-025 SHALL, for cmd_steps=0, accept the command, emit no transition, and pulse done_stb the cycle after acceptance.
REQ-026 SHALL preserve q across commands (outputs continue from last phase).
REQ-027 SHALL, on sw_valid & sw_ready, drive encoder_sw=0 for exactly max(sw_hold,1) clocks starting the next cycle, sw_ready low meanwhile, then encoder_sw=1.
REQ-028 SHALL run switch and rotation generators independently; simultaneous requests SHALL both be accepted.

Reset
REQ-029 SHALL on rst set q=0 (A=0,B=0), encoder_sw=1, cmd_ready=1, sw_ready=1, busy=0, done_stb=0, all counters zero, state IDLE.
REQ-030 SHALL on rst mid-command abort immediately without done_stb; rst has priority over cmd_valid/sw_valid in the same cycle.

Configuration
REQ-031 SHALL, with macro QUAD_ENCODER_GEN_BOUNCE_EN defined, follow each transition by 2*BOUNCE_COUNT alternations of the changed line (old, new, old, new...) each lasting BOUNCE_CYCLES clocks, settling at the new value; the unchanged line stays constant; done_stb waits until bounce ends.
REQ-032 SHALL, without QUAD_ENCODER_GEN_BOUNCE_EN, produce clean single edges and contain no bounce logic; switch line SHALL never bounce in either build.
REQ-033 SHALL require STEP_PERIOD > 2*BOUNCE_COUNT*BOUNCE_CYCLES when bounce is enabled (checked by assertion in simulation).

Verification (STEP_PERIOD=8, BOUNCE_COUNT=2, BOUNCE_CYCLES=1 in sim)
REQ-034 SHALL cover: reset, cw command steps=5 -> BA 01,11,10,00,01 at 8,16,24,32,40 clocks after accept; done_stb one cycle at 41.
REQ-035 SHALL cover: then ccw steps=2 -> BA 00,10; q wraps 0->3 correctly; cmd_valid during busy ignored.
REQ-036 SHALL cover: steps=0 -> no A/B change, done_stb cycle after accept, cmd_ready high next cycle.
REQ-037 SHALL cover: sw_hold=3 with simultaneous cw steps=1 -> encoder_sw low exactly 3 clocks, A rises at 8 clocks.
REQ-038 SHALL cover: rst asserted at clock 20 of steps=10 -> A=B=0, sw=1, no done_stb, cmd_ready=1 next cycle.
REQ-039 SHALL cover: with bounce macro, one cw step -> A sequence 1,0,1,0,1 per clock after transition, B stable 0; output through rotaryEncoder-class debouncer yields single clockwise state change.

Source files
------------

// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: rotary-encoder stimulus generator.
// Emits quadrature A/B steps at a fixed period and switch presses of a
// programmable length. The two generators run independently.
// Build option: define QUAD_ENCODER_GEN_BOUNCE_EN to add contact bounce
// after every A/B transition (the switch line never bounces).
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a rotation command
// WAIT   | counting down to the next transition
// STEP   | apply one transition, decide whether more remain
// BOUNCE | (bounce build) toggling the changed line, period timer runs on
// DONE   | raise done_stb for one cycle, then return to IDLE

module quad_encoder_gen #(
    parameter int STEP_PERIOD   = 98304,
    parameter int BOUNCE_COUNT  = 3,
    parameter int BOUNCE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clockwise,
    input  logic [7:0]  cmd_steps,
    input  logic        sw_valid,
    output logic        sw_ready,
    input  logic [15:0] sw_hold,
    output logic        encoder_A,
    output logic        encoder_B,
    output logic        encoder_sw,
    output logic        busy,
    output logic        done_stb
);

    // WAIT plus the one-cycle STEP state together span STEP_PERIOD clocks.
    localparam int TW = $clog2(STEP_PERIOD);
    localparam logic [TW-1:0] WAIT_LOAD = TW'(STEP_PERIOD - 2);

`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
    localparam int BLW = $clog2(2 * BOUNCE_COUNT + 1);
    localparam int BTW = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [BLW-1:0] BOUNCE_LOAD = BLW'(2 * BOUNCE_COUNT);
    localparam logic [BTW-1:0] BTIME_LOAD  = BTW'(BOUNCE_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        STEP,
        DONE
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
        , BOUNCE
`endif
    } state_t;

    state_t          state;
    logic [1:0]      q;
    logic [1:0]      q_nx;
    logic [1:0]      ba_nx;
    logic            dir_cw;
    logic [7:0]      remaining;
    logic [TW-1:0]   period_timer;
    logic [15:0]     sw_timer;

`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
    logic [BLW-1:0]  bounce_left;
    logic [BTW-1:0]  bounce_timer;
    logic            bounce_on_a;
`endif

    // Gray mapping of the phase index onto {B,A}.
    function automatic logic [1:0] ba_of(input logic [1:0] idx);
        case (idx)
            2'd0:    ba_of = 2'b00;
            2'd1:    ba_of = 2'b01;
            2'd2:    ba_of = 2'b11;
            default: ba_of = 2'b10;
        endcase
    endfunction

    assign busy = ~cmd_ready;

    // Next phase in the latched direction; the 2-bit wrap gives mod-4 behaviour.
    always_comb begin
        q_nx  = dir_cw ? (q + 2'd1) : (q - 2'd1);
        ba_nx = ba_of(q_nx);
    end

    // Rotation FSM; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            q            <= 2'd0;
            encoder_A    <= 1'b0;
            encoder_B    <= 1'b0;
            cmd_ready    <= 1'b1;
            done_stb     <= 1'b0;
            dir_cw       <= 1'b0;
            remaining    <= 8'd0;
            period_timer <= '0;
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
            bounce_left  <= '0;
            bounce_timer <= '0;
            bounce_on_a  <= 1'b0;
`endif
        end else begin
            done_stb <= 1'b0;
            case (state)
                IDLE: begin
                    // cmd_ready comes back one cycle after the done pulse
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready    <= 1'b0;
                        dir_cw       <= cmd_clockwise;
                        remaining    <= cmd_steps;
                        period_timer <= WAIT_LOAD;
                        state        <= (cmd_steps == 8'd0) ? DONE : WAIT;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (period_timer == '0) begin
                        state <= STEP;
                    end else begin
                        period_timer <= period_timer - 1'b1;
                    end
                end
                STEP: begin
                    q            <= q_nx;
                    encoder_A    <= ba_nx[0];
                    encoder_B    <= ba_nx[1];
                    remaining    <= remaining - 8'd1;
                    period_timer <= WAIT_LOAD;
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
                    bounce_left  <= BOUNCE_LOAD;
                    bounce_timer <= BTIME_LOAD;
                    bounce_on_a  <= (ba_nx[0] != encoder_A);
                    if (BOUNCE_COUNT == 0) begin
                        state <= (remaining == 8'd1) ? DONE : WAIT;
                    end else begin
                        state <= BOUNCE;
                    end
`else
                    state <= (remaining == 8'd1) ? DONE : WAIT;
`endif
                end
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
                BOUNCE: begin
                    // period timer keeps running so step spacing is unaffected
                    if (period_timer != '0) begin
                        period_timer <= period_timer - 1'b1;
                    end
                    if (bounce_timer == '0) begin
                        if (bounce_on_a) begin
                            encoder_A <= ~encoder_A;
                        end else begin
                            encoder_B <= ~encoder_B;
                        end
                        bounce_timer <= BTIME_LOAD;
                        bounce_left  <= bounce_left - 1'b1;
                        if (bounce_left == BLW'(1)) begin
                            if (remaining == 8'd0) begin
                                state <= DONE;
                            end else if (period_timer == '0) begin
                                state <= STEP;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end else begin
                        bounce_timer <= bounce_timer - 1'b1;
                    end
                end
`endif
                DONE: begin
                    done_stb <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Switch press generator: low for max(sw_hold,1) clocks after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            encoder_sw <= 1'b1;
            sw_ready   <= 1'b1;
            sw_timer   <= 16'd0;
        end else if (sw_ready) begin
            if (sw_valid) begin
                encoder_sw <= 1'b0;
                sw_ready   <= 1'b0;
                sw_timer   <= (sw_hold == 16'd0) ? 16'd0 : (sw_hold - 16'd1);
            end
        end else if (sw_timer == 16'd0) begin
            encoder_sw <= 1'b1;
            sw_ready   <= 1'b1;
        end else begin
            sw_timer <= sw_timer - 16'd1;
        end
    end

`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
    // Bounce must finish before the next transition is due.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (STEP_PERIOD > 2 * BOUNCE_COUNT * BOUNCE_CYCLES);
        end
    end
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Testbench for quad_encoder_gen: command table plus reset sequence, with
// a scoreboard of expected output edges checked by a negedge monitor.
module tb_quad_encoder_gen;

    localparam int SP  = 8;
    localparam int BC  = 2;
    localparam int BCY = 1;
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
    localparam int BD = 2 * BC * BCY;
`else
    localparam int BD = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_clockwise = 1'b0;
    logic [7:0]  cmd_steps = 8'd0;
    logic        sw_valid = 1'b0;
    logic        sw_ready;
    logic [15:0] sw_hold = 16'd0;
    logic        encoder_A;
    logic        encoder_B;
    logic        encoder_sw;
    logic        busy;
    logic        done_stb;

    quad_encoder_gen #(
        .STEP_PERIOD  (SP),
        .BOUNCE_COUNT (BC),
        .BOUNCE_CYCLES(BCY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_clockwise(cmd_clockwise),
        .cmd_steps    (cmd_steps),
        .sw_valid     (sw_valid),
        .sw_ready     (sw_ready),
        .sw_hold      (sw_hold),
        .encoder_A    (encoder_A),
        .encoder_B    (encoder_B),
        .encoder_sw   (encoder_sw),
        .busy         (busy),
        .done_stb     (done_stb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {int cyc; logic [1:0] ba;} ba_ev_t;
    typedef struct {int cyc; logic val;} sw_ev_t;
    typedef struct {bit cw; int steps; bit sw_en; int hold; logic [1:0] final_ba;} vec_t;

    ba_ev_t exp_ba[$];
    sw_ev_t exp_sw[$];
    int     exp_done[$];
    bit     mon_skip = 1'b1;
    int     mq = 0;
    vec_t   vecs[8];

    function automatic logic [1:0] ba_of(input int idx);
        case (idx & 3)
            0:       ba_of = 2'b00;
            1:       ba_of = 2'b01;
            2:       ba_of = 2'b11;
            default: ba_of = 2'b10;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Expected {B,A} values for one transition (and its bounce, if built in).
    task automatic push_trans(input int t, input logic [1:0] old_ba,
                              input logic [1:0] new_ba, input int limit);
        ba_ev_t e;
        if (t < limit) begin
            e.cyc = t; e.ba = new_ba; exp_ba.push_back(e);
        end
`ifdef QUAD_ENCODER_GEN_BOUNCE_EN
        for (int i = 1; i <= 2 * BC; i++) begin
            e.cyc = t + i * BCY;
            e.ba  = (i % 2 == 1) ? old_ba : new_ba;
            if (e.cyc < limit) exp_ba.push_back(e);
        end
`endif
    endtask

    // Monitor: every output change must match the head of its queue.
    logic [1:0] prev_ba = 2'b00;
    logic       prev_sw = 1'b1;
    ba_ev_t     mb;
    sw_ev_t     ms;
    int         md;
    always @(negedge clk) begin
        if (!mon_skip) begin
            if ({encoder_B, encoder_A} != prev_ba) begin
                if (exp_ba.size() == 0) begin
                    check("ba_unexpected_edge", {encoder_B, encoder_A}, prev_ba);
                end else begin
                    mb = exp_ba.pop_front();
                    check("ba_edge_cycle", cyc, mb.cyc);
                    check("ba_edge_value", {encoder_B, encoder_A}, mb.ba);
                end
            end
            if (encoder_sw != prev_sw) begin
                if (exp_sw.size() == 0) begin
                    check("sw_unexpected_edge", encoder_sw, prev_sw);
                end else begin
                    ms = exp_sw.pop_front();
                    check("sw_edge_cycle", cyc, ms.cyc);
                    check("sw_edge_value", encoder_sw, ms.val);
                end
            end
            if (done_stb) begin
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    md = exp_done.pop_front();
                    check("done_cycle", cyc, md);
                end
            end
        end
        prev_ba = {encoder_B, encoder_A};
        prev_sw = encoder_sw;
    end

    task automatic run_vec(input vec_t v);
        int k;
        int done_cyc;
        int sw_end;
        int h;
        sw_ev_t s;
        @(negedge clk);
        check("cmd_ready_before", cmd_ready, 1);
        k = cyc + 1;
        for (int i = 0; i < v.steps; i++) begin
            logic [1:0] old_ba;
            old_ba = ba_of(mq);
            mq = v.cw ? (mq + 1) & 3 : (mq + 3) & 3;
            push_trans(k + SP * (i + 1), old_ba, ba_of(mq), 32'h7fffffff);
        end
        done_cyc = (v.steps == 0) ? k + 1 : k + SP * v.steps + BD + 1;
        exp_done.push_back(done_cyc);
        sw_end = k;
        if (v.sw_en) begin
            check("sw_ready_before", sw_ready, 1);
            h = (v.hold == 0) ? 1 : v.hold;
            s.cyc = k;     s.val = 1'b0; exp_sw.push_back(s);
            s.cyc = k + h; s.val = 1'b1; exp_sw.push_back(s);
            sw_end = k + h;
            sw_valid = 1'b1;
            sw_hold  = 16'(v.hold);
        end
        cmd_valid     = 1'b1;
        cmd_clockwise = v.cw;
        cmd_steps     = 8'(v.steps);
        @(negedge clk);
        // garbage on the command inputs must not disturb the running command
        cmd_clockwise = ~v.cw;
        cmd_steps     = 8'(v.steps + 3);
        sw_valid      = 1'b0;
        if (v.steps == 0) cmd_valid = 1'b0;
        check("cmd_ready_after_accept", cmd_ready, 0);
        check("busy_after_accept", busy, 1);
        if (v.sw_en) check("sw_ready_after_accept", sw_ready, 0);
        if (v.steps > 0) begin
            repeat (3) @(negedge clk);
            cmd_valid = 1'b0;
        end
        while (cyc < done_cyc) @(negedge clk);
        check("cmd_ready_at_done", cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after_done", cmd_ready, 1);
        check("busy_after_done", busy, 0);
        check("final_ba", {encoder_B, encoder_A}, v.final_ba);
        while (cyc <= sw_end) @(negedge clk);
        if (v.sw_en) check("sw_ready_after_press", sw_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        vecs[0] = '{cw: 1'b1, steps: 5, sw_en: 1'b0, hold: 0, final_ba: 2'b01};
        vecs[1] = '{cw: 1'b0, steps: 2, sw_en: 1'b0, hold: 0, final_ba: 2'b10};
        vecs[2] = '{cw: 1'b1, steps: 0, sw_en: 1'b0, hold: 0, final_ba: 2'b10};
        vecs[3] = '{cw: 1'b1, steps: 1, sw_en: 1'b1, hold: 3, final_ba: 2'b00};
        vecs[4] = '{cw: 1'b1, steps: 1, sw_en: 1'b1, hold: 0, final_ba: 2'b01};
        vecs[5] = '{cw: 1'b0, steps: 3, sw_en: 1'b0, hold: 0, final_ba: 2'b11};
        vecs[6] = '{cw: 1'b1, steps: 4, sw_en: 1'b1, hold: 5, final_ba: 2'b11};
        vecs[7] = '{cw: 1'b1, steps: 2, sw_en: 1'b0, hold: 0, final_ba: 2'b00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ba", {encoder_B, encoder_A}, 0);
        check("reset_sw", encoder_sw, 1);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_sw_ready", sw_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done_stb, 0);
        mon_skip = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset 20 clocks into a 10-step command, with a long press running
        @(negedge clk);
        k = cyc + 1;
        push_trans(k + SP,     2'b00, 2'b01, k + 20);
        push_trans(k + 2 * SP, 2'b01, 2'b11, k + 20);
        exp_sw.push_back('{cyc: k, val: 1'b0});
        cmd_valid = 1'b1; cmd_clockwise = 1'b1; cmd_steps = 8'd10;
        sw_valid  = 1'b1; sw_hold = 16'd100;
        @(negedge clk);
        cmd_valid = 1'b0; sw_valid = 1'b0;
        while (cyc < k + 19) @(negedge clk);
        mon_skip  = 1'b1;
        rst       = 1'b1;
        cmd_valid = 1'b1;
        sw_valid  = 1'b1;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0; sw_valid = 1'b0;
        check("rst_mid_ba", {encoder_B, encoder_A}, 0);
        check("rst_mid_sw", encoder_sw, 1);
        check("rst_mid_done", done_stb, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        check("rst_mid_sw_ready", sw_ready, 1);
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        mon_skip = 1'b0;
        repeat (60) @(negedge clk);

        check("leftover_ba_events", exp_ba.size(), 0);
        check("leftover_sw_events", exp_sw.size(), 0);
        check("leftover_done_events", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
